// File: rtl/i2c_pkg.sv
// Shared types for the I2C target responder: FSM state encoding,
// ACK/NACK bus levels and the bit counter width.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CMD_RX,
        ST_CMD_ACK,
        ST_TX_BYTE,
        ST_TX_ACKCHK,
        ST_WAIT_STOP
    } i2c_tgt_state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam int   BIT_CNT_W = 4;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser and bus event detector.
// Ports: clk, rst_n, scl_i, sda_i in; sda (synced level), scl_rise,
// scl_fall, start_det, stop_det (1-cycle pulses) out.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;

    // Reset to 1: an idle bus reads high, so no false edge at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
            scl_q  <= scl_ff[SYNC_STAGES-1];
            sda_q  <= sda_ff[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda       = sda_ff[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match + ACK, command byte receive, N-byte read.
// Ports: clk, rst_n, scl_i, sda_i, resp_data, resp_ready, nack_inject in;
// sda_oe, cmd_byte, cmd_valid, rd_done, bytes_sent, busy out.
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h44,
    parameter int         N_RESP      = 6,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                sda_oe,
    input  logic [8*N_RESP-1:0] resp_data,
    input  logic                resp_ready,
    input  logic                nack_inject,
    output logic [7:0]          cmd_byte,
    output logic                cmd_valid,
    output logic                rd_done,
    output logic [3:0]          bytes_sent,
    output logic                busy
);

    localparam int RW = 8 * N_RESP;

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_tgt_state_t       state, state_n;
    logic [6:0]           shift, shift_n;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic                 ack_seen, ack_seen_n;
    logic                 rw, rw_n;
    logic [7:0]           tx_sr, tx_sr_n;
    logic [RW-1:0]        resp_buf, resp_buf_n;
    logic [3:0]           byte_idx, byte_idx_n;
    logic                 tx_fill, tx_fill_n;
    logic                 sda_oe_n;
    logic [7:0]           cmd_byte_n;
    logic                 cmd_valid_n;
    logic                 rd_done_n;
    logic [3:0]           bytes_sent_n;
    logic                 busy_n;
    logic                 fall_d;
    logic [7:0]           rx_byte;
    logic [RW-1:0]        resp_sh;
    logic                 addr_ok;

    assign rx_byte = {shift, sda_s};
    assign resp_sh = resp_buf << 8;
    assign addr_ok = (rx_byte[7:1] == ADDR) && !nack_inject
                   && (!rx_byte[0] || resp_ready);

    // SDA output only moves on the cycle after a detected SCL fall,
    // giving hold time behind the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            ack_seen   <= 1'b0;
            rw         <= 1'b0;
            tx_sr      <= '0;
            resp_buf   <= '0;
            byte_idx   <= '0;
            tx_fill    <= 1'b0;
            sda_oe     <= 1'b0;
            cmd_byte   <= 8'h00;
            cmd_valid  <= 1'b0;
            rd_done    <= 1'b0;
            bytes_sent <= '0;
            busy       <= 1'b0;
            fall_d     <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_cnt    <= bit_cnt_n;
            ack_seen   <= ack_seen_n;
            rw         <= rw_n;
            tx_sr      <= tx_sr_n;
            resp_buf   <= resp_buf_n;
            byte_idx   <= byte_idx_n;
            tx_fill    <= tx_fill_n;
            sda_oe     <= sda_oe_n;
            cmd_byte   <= cmd_byte_n;
            cmd_valid  <= cmd_valid_n;
            rd_done    <= rd_done_n;
            bytes_sent <= bytes_sent_n;
            busy       <= busy_n;
            fall_d     <= scl_fall;
        end
    end

    always_comb begin
        state_n      = state;
        shift_n      = shift;
        bit_cnt_n    = bit_cnt;
        ack_seen_n   = ack_seen;
        rw_n         = rw;
        tx_sr_n      = tx_sr;
        resp_buf_n   = resp_buf;
        byte_idx_n   = byte_idx;
        tx_fill_n    = tx_fill;
        sda_oe_n     = sda_oe;
        cmd_byte_n   = cmd_byte;
        cmd_valid_n  = 1'b0;
        rd_done_n    = 1'b0;
        bytes_sent_n = bytes_sent;
        busy_n       = busy;

        unique case (state)
            ST_IDLE: begin
                sda_oe_n = 1'b0;
            end
            ST_ADDR: begin
                if (scl_rise) begin
                    shift_n   = rx_byte[6:0];
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        if (addr_ok) begin
                            state_n    = ST_ADDR_ACK;
                            rw_n       = rx_byte[0];
                            busy_n     = 1'b1;
                            ack_seen_n = 1'b0;
                            if (rx_byte[0]) begin
                                resp_buf_n   = resp_data;
                                tx_sr_n      = resp_data[RW-1 -: 8];
                                byte_idx_n   = '0;
                                tx_fill_n    = 1'b0;
                                bytes_sent_n = '0;
                            end
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
            end
            // Shared 9th-clock ACK: drive after the 8th fall,
            // hand over after the 9th fall.
            ST_ADDR_ACK, ST_CMD_ACK: begin
                if (scl_rise) begin
                    ack_seen_n = 1'b1;
                end
                if (fall_d) begin
                    if (!ack_seen) begin
                        sda_oe_n = ~I2C_ACK;
                    end else begin
                        bit_cnt_n = '0;
                        if (state == ST_CMD_ACK || !rw) begin
                            state_n  = ST_CMD_RX;
                            sda_oe_n = 1'b0;
                        end else begin
                            state_n  = ST_TX_BYTE;
                            sda_oe_n = ~tx_sr[7];
                        end
                    end
                end
            end
            ST_CMD_RX: begin
                if (scl_rise) begin
                    shift_n   = rx_byte[6:0];
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        cmd_byte_n  = rx_byte;
                        cmd_valid_n = 1'b1;
                        state_n     = ST_CMD_ACK;
                        ack_seen_n  = 1'b0;
                    end
                end
            end
            ST_TX_BYTE: begin
                if (scl_rise) begin
                    tx_sr_n   = {tx_sr[6:0], 1'b1};
                    bit_cnt_n = bit_cnt + 4'd1;
                end
                if (fall_d) begin
                    if (bit_cnt == 4'd8) begin
                        state_n    = ST_TX_ACKCHK;
                        sda_oe_n   = 1'b0;
                        ack_seen_n = 1'b0;
                    end else begin
                        sda_oe_n = ~tx_sr[7];
                    end
                end
            end
            ST_TX_ACKCHK: begin
                if (scl_rise) begin
                    bytes_sent_n = sat_inc4(bytes_sent);
                    ack_seen_n   = 1'b1;
                    if (sda_s == I2C_NACK) begin
                        rd_done_n = 1'b1;
                        state_n   = ST_WAIT_STOP;
                    end else if (tx_fill ||
                                 byte_idx == 4'(N_RESP - 1)) begin
                        // Past the last byte: idle-high filler.
                        tx_fill_n = 1'b1;
                        tx_sr_n   = 8'hFF;
                    end else begin
                        byte_idx_n = byte_idx + 4'd1;
                        resp_buf_n = resp_sh;
                        tx_sr_n    = resp_sh[RW-1 -: 8];
                    end
                end
                if (fall_d && ack_seen) begin
                    state_n   = ST_TX_BYTE;
                    bit_cnt_n = '0;
                    sda_oe_n  = ~tx_sr[7];
                end
            end
            ST_WAIT_STOP: begin
                sda_oe_n = 1'b0;
            end
            default: begin
                state_n  = ST_IDLE;
                sda_oe_n = 1'b0;
            end
        endcase

        // Bus conditions override the per-state step; a command
        // pulse computed above still goes out.
        if (stop_det) begin
            state_n   = ST_IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            rd_done_n = (state == ST_TX_BYTE) ||
                        (state == ST_TX_ACKCHK);
        end else if (start_det) begin
            state_n    = ST_ADDR;
            sda_oe_n   = 1'b0;
            bit_cnt_n  = '0;
            ack_seen_n = 1'b0;
            tx_fill_n  = 1'b0;
        end
    end

endmodule
